// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and helpers for the scanned counter display.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [7:0] SEG_DP_OFF = 8'h80;

    // Active-low segment patterns {dp,g,f,e,d,c,b,a} for nibble values 0..F
    localparam logic [7:0] SEG7_TABLE [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Decode one nibble; the decimal point is forced off
    function automatic logic [7:0] seg7_decode(input logic [3:0] nibble);
        return SEG7_TABLE[nibble] | SEG_DP_OFF;
    endfunction

    // Limit a loaded nibble to the highest legal digit value
    function automatic logic [3:0] nibble_clamp(input logic [3:0] nibble,
                                                input logic [3:0] max_val);
        return (nibble > max_val) ? max_val : nibble;
    endfunction

endpackage

// File: rtl/seg7_digit_cell.sv
// One counter digit: registered nibble with increment/decrement/load and
// combinational carry/borrow out to the next digit of the chain.
module seg7_digit_cell
    import seg7_pkg::*;
#(
    parameter int DIGIT_MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       inc,
    input  logic       dec,
    output logic       carry,
    output logic       borrow,
    output logic [3:0] digit_q
);

    localparam logic [3:0] DMAX = 4'(DIGIT_MAX);

    logic [3:0] digit_d;

    assign carry  = inc && (digit_q == DMAX);
    assign borrow = dec && (digit_q == 4'd0);

    // Next digit value: load beats stepping; inc and dec are never both set
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = nibble_clamp(load_val, DMAX);
        end else if (inc) begin
            digit_d = (digit_q == DMAX) ? 4'd0 : digit_q + 4'd1;
        end else if (dec) begin
            digit_d = (digit_q == 4'd0) ? DMAX : digit_q - 4'd1;
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/seg7_scan_counter.sv
// Multi-digit up/down counter with prescaled stepping, wrap/saturate terminal
// handling and a multiplexed common-anode 7-segment scan driver.
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int DIGIT_MAX = 9,
    parameter int TICK_DIV  = 16777216,
    parameter int SCAN_DIV  = 50000,
    parameter int WRAP_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  dir,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
    localparam int IW = ($clog2(DIGITS) < 1) ? 1 : $clog2(DIGITS);

    localparam logic [3:0]        DMAX       = 4'(DIGIT_MAX);
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]     SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_RESET   = ~DIGITS'(1);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $fatal(1, "seg7_scan_counter: DIGITS must be 1..8");
    end
    if (DIGIT_MAX < 1 || DIGIT_MAX > 15) begin : g_bad_digit_max
        $fatal(1, "seg7_scan_counter: DIGIT_MAX must be 1..15");
    end
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $fatal(1, "seg7_scan_counter: TICK_DIV must be >= 2");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $fatal(1, "seg7_scan_counter: SCAN_DIV must be >= 1");
    end
    if (WRAP_MODE != 0 && WRAP_MODE != 1) begin : g_bad_wrap_mode
        $fatal(1, "seg7_scan_counter: WRAP_MODE must be 0 or 1");
    end

    logic [PW-1:0]     presc_q, presc_d;
    logic              tick_s;
    logic              step_en_s;
    logic [DIGITS:0]   inc_s;
    logic [DIGITS:0]   dec_s;
    logic [3:0]        digit_s [0:DIGITS-1];
    logic              all_max_s, all_zero_s, pre_up_s, pre_dn_s;
    logic              at_term_s, pre_term_s;
    logic              wrap_q, wrap_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    assign tick_s = run && (presc_q == PRESC_LAST);

    // Prescaler: free-runs only while run is high, load restarts the phase
    always_comb begin
        presc_d = presc_q;
        if (load) begin
            presc_d = {PW{1'b0}};
        end else if (tick_s) begin
            presc_d = {PW{1'b0}};
        end else if (run) begin
            presc_d = presc_q + PW'(1);
        end else begin
            presc_d = presc_q;
        end
    end

    // Terminal detection: at the terminal now, or one step short of it
    always_comb begin
        all_max_s  = 1'b1;
        all_zero_s = 1'b1;
        pre_up_s   = 1'b1;
        pre_dn_s   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            all_max_s  = all_max_s  & (digit_s[i] == DMAX);
            all_zero_s = all_zero_s & (digit_s[i] == 4'd0);
            pre_up_s   = pre_up_s   & (digit_s[i] == ((i == 0) ? DMAX - 4'd1 : DMAX));
            pre_dn_s   = pre_dn_s   & (digit_s[i] == ((i == 0) ? 4'd1 : 4'd0));
        end
        at_term_s  = dir ? all_max_s : all_zero_s;
        pre_term_s = dir ? pre_up_s  : pre_dn_s;
    end

    // A saturating counter refuses to step past its terminal in the current direction
    assign step_en_s = tick_s && !load && ((WRAP_MODE != 0) || !at_term_s);
    assign inc_s[0]  = step_en_s && dir;
    assign dec_s[0]  = step_en_s && !dir;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_digit_cell #(
            .DIGIT_MAX (DIGIT_MAX)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .load     (load),
            .load_val (load_val[4*g +: 4]),
            .inc      (inc_s[g]),
            .dec      (dec_s[g]),
            .carry    (inc_s[g+1]),
            .borrow   (dec_s[g+1]),
            .digit_q  (digit_s[g])
        );
        assign value[4*g +: 4] = digit_s[g];
    end

    // Wrap pulse: carry/borrow out of the top digit, or the step that lands on saturation
    always_comb begin
        wrap_d = 1'b0;
        if (load) begin
            wrap_d = 1'b0;
        end else if (WRAP_MODE != 0) begin
            wrap_d = inc_s[DIGITS] | dec_s[DIGITS];
        end else begin
            wrap_d = step_en_s && pre_term_s;
        end
    end

    // Prescaler and wrap pulse registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= {PW{1'b0}};
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            wrap_q  <= wrap_d;
        end
    end

    // Scan FSM state register: slot timer and current digit index
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_q <= {SW{1'b0}};
            idx_q  <= {IW{1'b0}};
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
        end
    end

    // Scan FSM next state: advance the index at the end of each slot
    always_comb begin
        scan_d = scan_q;
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = {SW{1'b0}};
            idx_d  = (idx_q == IDX_LAST) ? {IW{1'b0}} : idx_q + IW'(1);
        end else begin
            scan_d = scan_q + SW'(1);
            idx_d  = idx_q;
        end
    end

    // Scan FSM outputs: enable the indexed anode and decode its digit
    always_comb begin
        an_d  = {DIGITS{1'b1}};
        seg_d = SEG_BLANK;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                an_d[i] = 1'b0;
                seg_d   = seg7_decode(digit_s[i]);
            end else begin
                an_d[i] = 1'b1;
            end
        end
    end

    // Display pin registers so anode and segments switch on the same edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            an_q  <= AN_RESET;
            seg_q <= seg7_decode(4'd0);
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign wrap = wrap_q;

endmodule

// File: doc/seg7_scan_counter.md
Name: seg7_scan_counter

Overview:
Parametrised successor to the single-digit state-sequencer display block. It drives a DIGITS-wide up/down counter shown on multiplexed common-anode 7-segment displays, one digit per scan slot. The block has a run/pause control, a synchronous load, a direction select, and a choice of wrap-around or saturating terminal behaviour. It sits between board-level push-button/switch logic and the display pins.

Parameters:
DIGITS, 4, number of display digits (1..8)
DIGIT_MAX, 9, highest value per digit (1..15); 9 gives a decimal count, 15 gives hex
TICK_DIV, 16777216, clk cycles per count step (>=2)
SCAN_DIV, 50000, clk cycles per digit scan slot (>=1)
WRAP_MODE, 1, 1 = wrap at the terminal value; 0 = saturate and stop

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-low reset
run  in  1  1 = prescaler advances and count steps occur; 0 = pause
dir  in  1  1 = count up, 0 = count down
load  in  1  synchronous load strobe
load_val  in  4*DIGITS  digit values to load, digit 0 in LSBs
seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp is always 1 (off)
an  out  DIGITS  active-low digit enables, one-hot-low
value  out  4*DIGITS  current count digits, registered
wrap  out  1  one-cycle pulse on terminal crossing (wrap or saturation reached)

Behaviour:
- Reset (rst=0 at a clk edge):
  - all digits = 0, prescaler = 0, scan counter = 0, scan index = 0.
  - wrap = 0, an = ~1 (digit 0 enabled), seg = 8'hC0.
  - Reset wins over every other input.
- Prescaler:
  - counts 0..TICK_DIV-1 only while run=1; holds its value while run=0, so pause keeps the phase.
  - tick = run && prescaler==TICK_DIV-1; the prescaler returns to 0 on that cycle.
- Count step on tick:
  - Up: digit 0 increments. A digit at DIGIT_MAX goes to 0 and carries into the next digit (ripple in the same cycle).
  - Down: a digit at 0 goes to DIGIT_MAX and borrows from the next digit.
- Terminal value: all digits = DIGIT_MAX when counting up, all digits = 0 when counting down.
  - WRAP_MODE=1: stepping past the terminal wraps to all-0 (up) or all-DIGIT_MAX (down), and wrap=1 in the cycle after the tick.
  - WRAP_MODE=0: the step that reaches the terminal pulses wrap. Further ticks in the same direction are ignored (the count holds). Changing dir allows counting again.
- Load:
  - load=1 copies load_val into the digits and clears the prescaler. Load has priority over a coincident tick; no step occurs that cycle.
  - A load_val nibble greater than DIGIT_MAX is clamped to DIGIT_MAX.
  - wrap is not asserted by a load.
- dir may change on any cycle; it takes effect at the next tick.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1 continuously; run has no effect on it.
  - At its terminal value the scan index advances 0→1→…→DIGITS-1→0.
  - an and seg are registered, and change together one cycle after the index changes. an[idx]=0, all other bits 1; seg = decode(digit[idx]).
  - DIGITS=1: an is held at 0.
- Decode table (hex): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Widths: the prescaler is $clog2(TICK_DIV) bits, the scan counter is max(1,$clog2(SCAN_DIV)) bits, and the index is max(1,$clog2(DIGITS)) bits. All comparisons are done at full width, with no truncation.
- Elaboration: out-of-range parameters trigger a fatal assertion.

Decomposition:
- Shared package seg7_pkg:
  - the 16-entry active-low segment constant array;
  - the constants SEG_BLANK=8'hFF and SEG_DP_OFF;
  - the function seg7_decode(nibble).
- Sub-module seg7_digit_cell: one digit. It takes inc/dec/load inputs, produces carry/borrow out, and its output is the registered nibble. It is instantiated DIGITS times in a generate chain.
- The top level holds the prescaler, the terminal/wrap logic and the scan FSM.

Test Plan:
(Bench uses DIGITS=2, DIGIT_MAX=9, TICK_DIV=4, SCAN_DIV=2.)
- Hold rst=0 for 3 cycles with run=1 → value=00, seg=C0, an=2'b10, wrap=0. Release rst → first step at cycle 4, value=01.
- run=1, dir=1 from 98 → 99 then 00. wrap pulses for exactly 1 cycle after the 99→00 tick. With WRAP_MODE=0, the count holds at 99, with one wrap pulse on reaching 99.
- dir=0 from 10 → 09 (borrow) → 08. From 00 → 99 with a wrap pulse (WRAP_MODE=1).
- load=1 with load_val=8'hF3 coincident with a tick → value=93 (clamped), no step, prescaler=0, and the next step comes 4 cycles later.
- run=0 for 10 cycles mid-prescale → value and prescaler are frozen and scanning continues. Resume → the step arrives after the remaining prescale count.
- value=47 → an alternates 10/01 every 2 cycles, and seg is 8'hF8 with an=10 and 8'h99 with an=01. Assert rst=0 mid-scan → next edge gives an=10, seg=C0.
